// File: rtl/ftoi_arb_pkg.sv
// Shared types and helpers for the ftoi arbiter slice.
package ftoi_arb_pkg;

    localparam int unsigned LATENCY_FTOI = 2;
    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned ID_W_DEF     = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic                v;
        logic [ID_W_DEF-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W_DEF-1:0] id;
        logic [31:0]         data;
    } resp_t;

    typedef struct packed {
        logic                found;
        logic [ID_W_DEF-1:0] id;
    } pick_t;

    // Rotate so ptr is bit 0, take the lowest set bit, rotate the index back.
    function automatic pick_t rr_pick(input logic [N_REQ_DEF-1:0] req,
                                      input logic [ID_W_DEF-1:0]  ptr);
        logic [N_REQ_DEF-1:0] rot;
        int unsigned          off;
        pick_t                p;
        rot = '0;
        off = 0;
        p   = '0;
        for (int unsigned i = 0; i < N_REQ_DEF; i++)
            rot[ID_W_DEF'(i)] = req[ID_W_DEF'((i + 32'(ptr)) % N_REQ_DEF)];
        for (int unsigned i = 0; i < N_REQ_DEF; i++) begin
            if (rot[ID_W_DEF'(i)] && !p.found) begin
                p.found = 1'b1;
                off     = i;
            end
        end
        p.id = ID_W_DEF'((off + 32'(ptr)) % N_REQ_DEF);
        return p;
    endfunction

endpackage

// File: rtl/ftoi_arb_cvt.sv
// Two-stage float32 -> int32 converter, round half away from zero, saturating.
module ftoi_arb_cvt (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op,
    output logic [31:0] res
);

    logic [31:0] op_q;

    function automatic logic [31:0] f2i(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [23:0] x;
        logic [31:0] mag;
        logic [4:0]  sh;
        logic [31:0] r;
        s   = f[31];
        e   = f[30:23];
        x   = {1'b1, f[22:0]};
        mag = '0;
        sh  = '0;
        if (e >= 8'd158) begin
            r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            if (e < 8'd126) begin
                mag = '0;
            end else if (e >= 8'd150) begin
                mag = {8'b0, x} << (e - 8'd150);
            end else begin
                sh  = 5'(8'd150 - e);
                mag = ({8'b0, x} >> sh) + 32'(x[sh - 5'd1]);
            end
            r = s ? (~mag + 32'd1) : mag;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            res  <= '0;
        end else begin
            op_q <= op;
            res  <= f2i(op_q);
        end
    end

endmodule

// File: rtl/ftoi_arb_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module ftoi_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 34,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credits must make a push into a full FIFO without a pop impossible.
    assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));

endmodule

// File: rtl/ftoi_arbiter.sv
// Shares one ftoi converter among N_REQ requesters with credit-based result buffering.
// FTOI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ftoi_arbiter
    import ftoi_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned LATENCY    = LATENCY_FTOI,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = ID_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [32*N_REQ-1:0] req_op,
    output logic [N_REQ-1:0]  req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [ID_W-1:0]   resp_id,
    input  logic              resp_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + LATENCY + 1);

    tag_t              tag_q [LATENCY];
    logic [OCC_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              credit_ok;
    logic              issue;
    logic [ID_W-1:0]   grant_id;
    logic [31:0]       cvt_op;
    logic [31:0]       cvt_res;
    logic [31:0]       op_arr [N_REQ];
    pick_t             pick;
    resp_t             push_entry;
    resp_t             head;

    for (genvar g = 0; g < N_REQ; g++) begin : g_op
        assign op_arr[g] = req_op[32*g +: 32];
    end

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++)
            inflight = inflight + OCC_W'(tag_q[i].v);
    end

    // Every issued op owns a FIFO slot, so the converter never has to stall.
    assign credit_ok = (inflight + OCC_W'(fifo_count)) < OCC_W'(FIFO_DEPTH);

`ifndef FTOI_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rr_ptr <= '0;
        else if (issue) rr_ptr <= ID_W'((32'(grant_id) + 32'd1) % N_REQ);
    end
`endif

    always_comb begin
        req_ready = '0;
        issue     = 1'b0;
        grant_id  = '0;
        cvt_op    = '0;
`ifdef FTOI_ARB_FIXED_PRIO_EN
        pick = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[ID_W'(i)] && !pick.found) begin
                pick.found = 1'b1;
                pick.id    = ID_W'(i);
            end
        end
`else
        pick = rr_pick(req_valid, rr_ptr);
`endif
        if (pick.found && credit_ok && reset) begin
            issue               = 1'b1;
            grant_id            = pick.id;
            req_ready[pick.id]  = 1'b1;
            cvt_op              = op_arr[pick.id];
        end
    end

    // Tag pipe mirrors the converter latency so results pair with their requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{v: issue, id: grant_id};
            for (int unsigned i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    ftoi_arb_cvt u_cvt (
        .clk   (clk),
        .reset (reset),
        .op    (cvt_op),
        .res   (cvt_res)
    );

    assign push_entry = '{id: tag_q[LATENCY-1].id, data: cvt_res};

    ftoi_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(resp_t)),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_q[LATENCY-1].v),
        .push_data (push_entry),
        .pop       (resp_valid & resp_ready),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid = ~fifo_empty;
    assign resp_data  = head.data;
    assign resp_id    = head.id;
    assign busy       = (inflight != '0) | ~fifo_empty;

endmodule
